pkt_merge_arb: RTL and testbench

Two-input, packet-granular round-robin arbiter in the mkPktMerge datapath. It sits directly upstream of the 153-bit output FIFO and selects whole packets from input port 0 or port 1. Once a port wins, that port keeps the grant until its end-of-packet word has been accepted, so packets are never interleaved. Granted words pass through a one-entry output register and are written into the FIFO, with backpressure taken from the FIFO's space-available flag.

---
 rtl/pkt_merge_pkg.sv | 31 +++
 rtl/pkt_merge_arb_if.sv | 27 ++
 rtl/pkt_merge_obuf.sv | 56 +++++
 rtl/pkt_merge_arb.sv | 174 +++++++++++++++++
 tb/tb_pkt_merge_arb.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_merge_pkg.sv
// Shared constants and types for the two-port packet merge arbiter.
package pkt_merge_pkg;

  // Word layout: [152]=SOP, [151]=EOP, [150:0]=payload/metadata.
  localparam int DW      = 153;
  localparam int SOP_BIT = 152;
  localparam int EOP_BIT = 151;

  // Default width of the per-port packet counters.
  localparam int CW_DEF  = 16;

  // Width of the saturating drop counter.
  localparam int DROP_W  = 8;

  // Arbiter states: IDLE picks a packet, LOCKw serves port w until EOP.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

  // Saturating increment for the drop counter (sticks at all ones).
  function automatic logic [DROP_W-1:0] sat_inc8(input logic [DROP_W-1:0] v);
    if (v == {DROP_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(DROP_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/pkt_merge_arb_if.sv
// Handshake bundle between the two input ports, the arbiter and the output FIFO.
interface pkt_merge_arb_if;
  import pkt_merge_pkg::*;

  logic [DW-1:0] iport0_D;
  logic          iport0_VALID;
  logic          iport0_DEQ;
  logic [DW-1:0] iport1_D;
  logic          iport1_VALID;
  logic          iport1_DEQ;
  logic [DW-1:0] fo_D_IN;
  logic          fo_ENQ;
  logic          fo_FULL_N;

  // Arbiter side: pops input heads and pushes into the output FIFO.
  modport master (
    input  iport0_D, iport0_VALID, iport1_D, iport1_VALID, fo_FULL_N,
    output iport0_DEQ, iport1_DEQ, fo_D_IN, fo_ENQ
  );

  // Environment side: input queues and the output FIFO.
  modport slave (
    output iport0_D, iport0_VALID, iport1_D, iport1_VALID, fo_FULL_N,
    input  iport0_DEQ, iport1_DEQ, fo_D_IN, fo_ENQ
  );

endinterface

// File: rtl/pkt_merge_obuf.sv
// One-entry output register in front of the output FIFO. It can accept a
// new word in the same cycle the held word drains.
module pkt_merge_obuf
  import pkt_merge_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          full_n_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          enq_o
);

  logic          valid_q;
  logic          valid_d;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_d;
  logic          enq_s;

  // Drain whenever a word is held and the FIFO has room.
  always_comb begin
    enq_s = valid_q & full_n_i;
  end

  // Next-state: a load always wins; otherwise an enqueue empties the register.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (enq_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Register state; reset discards any held word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= 1'b0;
      data_q  <= {DW{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign enq_o   = enq_s;

endmodule

// File: rtl/pkt_merge_arb.sv
// Two-input packet-granular round-robin arbiter. A winning port keeps the
// grant until its EOP word is accepted; heads lacking SOP in IDLE are dropped.
module pkt_merge_arb
  import pkt_merge_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  pkt_merge_arb_if.master   bus,
  output logic [CW-1:0]     pkt_cnt0,
  output logic [CW-1:0]     pkt_cnt1,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CW-1:0]     pkt_cnt0_q, pkt_cnt0_d;
  logic [CW-1:0]     pkt_cnt1_q, pkt_cnt1_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              ob_valid_s;
  logic [DW-1:0]     ob_data_s;
  logic              ob_enq_s;
  logic              space_s;
  logic              win_s;
  logic              win_valid_s;
  logic [DW-1:0]     win_data_s;
  logic              deq0_s;
  logic              deq1_s;
  logic              load_s;
  logic [DW-1:0]     load_data_s;

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // Output register can take a word when empty or draining this cycle.
  always_comb begin
    space_s = ~ob_valid_s | bus.fo_FULL_N;
  end

  // IDLE candidate selection: on a tie the port that did not win last goes.
  always_comb begin
    win_valid_s = bus.iport0_VALID | bus.iport1_VALID;
    if (bus.iport0_VALID && bus.iport1_VALID) begin
      win_s = ~last_grant_q;
    end else if (bus.iport1_VALID) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    win_data_s = win_s ? bus.iport1_D : bus.iport0_D;
  end

  // Arbiter FSM next state, pops, output-register load and counter updates.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pkt_cnt0_d   = pkt_cnt0_q;
    pkt_cnt1_d   = pkt_cnt1_q;
    drop_cnt_d   = drop_cnt_q;
    deq0_s       = 1'b0;
    deq1_s       = 1'b0;
    load_s       = 1'b0;
    load_data_s  = {DW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (win_valid_s) begin
          if (win_data_s[SOP_BIT]) begin
            if (space_s) begin
              deq0_s       = ~win_s;
              deq1_s       = win_s;
              load_s       = 1'b1;
              load_data_s  = win_data_s;
              last_grant_d = win_s;
              if (win_data_s[EOP_BIT]) begin
                // Single-word packet: count it and stay ready for the next.
                if (win_s) begin
                  pkt_cnt1_d = pkt_cnt1_q + CNT_ONE;
                end else begin
                  pkt_cnt0_d = pkt_cnt0_q + CNT_ONE;
                end
              end else begin
                state_d = win_s ? ST_LOCK1 : ST_LOCK0;
              end
            end else begin
              load_s = 1'b0;
            end
          end else begin
            // Orphan word without SOP: discard it; needs no output space.
            deq0_s     = ~win_s;
            deq1_s     = win_s;
            drop_cnt_d = sat_inc8(drop_cnt_q);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK0: begin
        if (bus.iport0_VALID && space_s) begin
          deq0_s      = 1'b1;
          load_s      = 1'b1;
          load_data_s = bus.iport0_D;
          if (bus.iport0_D[EOP_BIT]) begin
            pkt_cnt0_d = pkt_cnt0_q + CNT_ONE;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_LOCK0;
          end
        end else begin
          state_d = ST_LOCK0;
        end
      end
      ST_LOCK1: begin
        if (bus.iport1_VALID && space_s) begin
          deq1_s      = 1'b1;
          load_s      = 1'b1;
          load_data_s = bus.iport1_D;
          if (bus.iport1_D[EOP_BIT]) begin
            pkt_cnt1_d = pkt_cnt1_q + CNT_ONE;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_LOCK1;
          end
        end else begin
          state_d = ST_LOCK1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant history and counters; last_grant=1 so port 0 wins first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      pkt_cnt0_q   <= {CW{1'b0}};
      pkt_cnt1_q   <= {CW{1'b0}};
      drop_cnt_q   <= {DROP_W{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pkt_cnt0_q   <= pkt_cnt0_d;
      pkt_cnt1_q   <= pkt_cnt1_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  pkt_merge_obuf u_obuf (
    .CLK      (CLK),
    .RST      (RST),
    .load_i   (load_s),
    .data_i   (load_data_s),
    .full_n_i (bus.fo_FULL_N),
    .valid_o  (ob_valid_s),
    .data_o   (ob_data_s),
    .enq_o    (ob_enq_s)
  );

  // Pops are suppressed while reset is held so no upstream word is lost.
  assign bus.iport0_DEQ = deq0_s & ~RST;
  assign bus.iport1_DEQ = deq1_s & ~RST;
  assign bus.fo_D_IN    = ob_data_s;
  assign bus.fo_ENQ     = ob_enq_s;

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = (state_q != ST_IDLE) | ob_valid_s;

endmodule

// File: tb/tb_pkt_merge_arb.sv
// Directed self-checking bench for pkt_merge_arb.
module tb_pkt_merge_arb;
  import pkt_merge_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [15:0] pkt_cnt0;
  logic [15:0] pkt_cnt1;
  logic [7:0]  drop_cnt;
  logic        busy;

  pkt_merge_arb_if bus_if ();

  pkt_merge_arb #(.CW(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus_if.master),
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] outq[$];
  logic [DW-1:0] expq[$];
  int n_assert = 0;
  int n_fail   = 0;
  logic          s_deq0, s_deq1, s_enq;
  logic [DW-1:0] s_din;
  logic          enq_log[8];

  function automatic logic [DW-1:0] mk(input logic sop, input logic eop, input logic [15:0] tag);
    return {sop, eop, 135'd0, tag};
  endfunction

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus_if.iport0_VALID = (q0.size() > 0);
    bus_if.iport0_D     = (q0.size() > 0) ? q0[0] : '0;
    bus_if.iport1_VALID = (q1.size() > 0);
    bus_if.iport1_D     = (q1.size() > 0) ? q1[0] : '0;
  endtask

  // One clock: sample at negedge, pop/collect, re-drive heads after posedge.
  task automatic tick();
    @(negedge CLK);
    s_deq0 = bus_if.iport0_DEQ;
    s_deq1 = bus_if.iport1_DEQ;
    s_enq  = bus_if.fo_ENQ;
    s_din  = bus_if.fo_D_IN;
    if (s_enq) outq.push_back(s_din);
    if (s_deq0 && q0.size() > 0) void'(q0.pop_front());
    if (s_deq1 && q1.size() > 0) void'(q1.pop_front());
    @(posedge CLK);
    #1;
    drive();
  endtask

  task automatic drain(input string tag, input int max);
    int k;
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy !== 1'b0) && k < max) begin
      tick();
      k++;
    end
    chkn({tag, "_drain_bound"}, 32'(k < max), 32'd1);
  endtask

  task automatic cmp_out(input string tag);
    chkn({tag, "_count"}, 32'(outq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      chkw($sformatf("%s_word%0d", tag, i), outq[i], expq[i]);
    end
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    bus_if.fo_FULL_N = 1'b1;
    drive();
    repeat (2) @(posedge CLK);
    #1;
    chkn("rst_enq", 32'(bus_if.fo_ENQ), 32'd0);
    chkn("rst_deq0", 32'(bus_if.iport0_DEQ), 32'd0);
    chkn("rst_deq1", 32'(bus_if.iport1_DEQ), 32'd0);
    chkn("rst_busy", 32'(busy), 32'd0);
    chkn("rst_pkt0", 32'(pkt_cnt0), 32'd0);
    chkn("rst_pkt1", 32'(pkt_cnt1), 32'd0);
    chkn("rst_drop", 32'(drop_cnt), 32'd0);
    RST = 1'b0;

    // Port 0 alone, 3-word packet.
    q0.push_back(mk(1'b1, 1'b0, 16'h0101));
    q0.push_back(mk(1'b0, 1'b0, 16'h0102));
    q0.push_back(mk(1'b0, 1'b1, 16'h0103));
    drive();
    tick();
    chkn("t1_first_deq", 32'(s_deq0), 32'd1);
    chkn("t1_no_enq_yet", 32'(s_enq), 32'd0);
    tick();
    chkn("t1_enq_a", 32'(s_enq), 32'd1);
    chkw("t1_data_a", s_din, mk(1'b1, 1'b0, 16'h0101));
    tick();
    chkn("t1_enq_b", 32'(s_enq), 32'd1);
    chkw("t1_data_b", s_din, mk(1'b0, 1'b0, 16'h0102));
    tick();
    chkn("t1_enq_c", 32'(s_enq), 32'd1);
    chkw("t1_data_c", s_din, mk(1'b0, 1'b1, 16'h0103));
    chkn("t1_deq_after", 32'(s_deq0), 32'd0);
    chkn("t1_pkt0", 32'(pkt_cnt0), 32'd1);
    chkn("t1_busy", 32'(busy), 32'd0);

    // Both ports contend with 2-word packets; port 0 first after reset.
    pulse_reset();
    outq.delete();
    q0.push_back(mk(1'b1, 1'b0, 16'h0201)); q0.push_back(mk(1'b0, 1'b1, 16'h0202));
    q0.push_back(mk(1'b1, 1'b0, 16'h0203)); q0.push_back(mk(1'b0, 1'b1, 16'h0204));
    q1.push_back(mk(1'b1, 1'b0, 16'h0211)); q1.push_back(mk(1'b0, 1'b1, 16'h0212));
    q1.push_back(mk(1'b1, 1'b0, 16'h0213)); q1.push_back(mk(1'b0, 1'b1, 16'h0214));
    drive();
    drain("t2", 30);
    expq.delete();
    expq.push_back(mk(1'b1, 1'b0, 16'h0201)); expq.push_back(mk(1'b0, 1'b1, 16'h0202));
    expq.push_back(mk(1'b1, 1'b0, 16'h0211)); expq.push_back(mk(1'b0, 1'b1, 16'h0212));
    expq.push_back(mk(1'b1, 1'b0, 16'h0203)); expq.push_back(mk(1'b0, 1'b1, 16'h0204));
    expq.push_back(mk(1'b1, 1'b0, 16'h0213)); expq.push_back(mk(1'b0, 1'b1, 16'h0214));
    cmp_out("t2");
    chkn("t2_pkt0", 32'(pkt_cnt0), 32'd2);
    chkn("t2_pkt1", 32'(pkt_cnt1), 32'd2);

    // Backpressure mid-packet; port 1 waits behind the lock.
    outq.delete();
    q0.push_back(mk(1'b1, 1'b0, 16'h0301)); q0.push_back(mk(1'b0, 1'b0, 16'h0302));
    q0.push_back(mk(1'b0, 1'b0, 16'h0303)); q0.push_back(mk(1'b0, 1'b1, 16'h0304));
    q1.push_back(mk(1'b1, 1'b1, 16'h0311));
    drive();
    tick();
    chkn("t3_deq0_first", 32'(s_deq0), 32'd1);
    chkn("t3_deq1_first", 32'(s_deq1), 32'd0);
    tick();
    bus_if.fo_FULL_N = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chkn("t3_stall_enq", 32'(s_enq), 32'd0);
      chkn("t3_stall_deq0", 32'(s_deq0), 32'd0);
      chkn("t3_stall_deq1", 32'(s_deq1), 32'd0);
      chkw("t3_stall_hold", s_din, mk(1'b0, 1'b0, 16'h0302));
    end
    bus_if.fo_FULL_N = 1'b1;
    tick();
    chkn("t3_resume_enq", 32'(s_enq), 32'd1);
    chkw("t3_resume_data", s_din, mk(1'b0, 1'b0, 16'h0302));
    chkn("t3_resume_deq0", 32'(s_deq0), 32'd1);
    drain("t3", 20);
    expq.delete();
    expq.push_back(mk(1'b1, 1'b0, 16'h0301)); expq.push_back(mk(1'b0, 1'b0, 16'h0302));
    expq.push_back(mk(1'b0, 1'b0, 16'h0303)); expq.push_back(mk(1'b0, 1'b1, 16'h0304));
    expq.push_back(mk(1'b1, 1'b1, 16'h0311));
    cmp_out("t3");
    chkn("t3_pkt0", 32'(pkt_cnt0), 32'd3);
    chkn("t3_pkt1", 32'(pkt_cnt1), 32'd3);

    // Orphan words on port 1 while IDLE; drop counter saturates.
    outq.delete();
    q1.push_back(mk(1'b0, 1'b0, 16'h0401));
    drive();
    tick();
    chkn("t4_drop_deq", 32'(s_deq1), 32'd1);
    chkn("t4_drop_noenq", 32'(s_enq), 32'd0);
    chkn("t4_drop_cnt1", 32'(drop_cnt), 32'd1);
    tick();
    chkn("t4_drop_noenq2", 32'(s_enq), 32'd0);
    for (int i = 0; i < 299; i++) q1.push_back(mk(1'b0, 1'b1, 16'(i)));
    drive();
    drain("t4", 400);
    chkn("t4_drop_sat", 32'(drop_cnt), 32'd255);
    chkn("t4_no_output", 32'(outq.size()), 32'd0);
    chkn("t4_pkt1", 32'(pkt_cnt1), 32'd3);

    // Single-word packets from both ports every cycle.
    outq.delete();
    q0.push_back(mk(1'b1, 1'b1, 16'h0501)); q0.push_back(mk(1'b1, 1'b1, 16'h0502));
    q0.push_back(mk(1'b1, 1'b1, 16'h0503));
    q1.push_back(mk(1'b1, 1'b1, 16'h0511)); q1.push_back(mk(1'b1, 1'b1, 16'h0512));
    q1.push_back(mk(1'b1, 1'b1, 16'h0513));
    drive();
    for (int i = 0; i < 7; i++) begin
      tick();
      enq_log[i] = s_enq;
    end
    for (int i = 1; i < 7; i++) chkn($sformatf("t5_enq_cycle%0d", i), 32'(enq_log[i]), 32'd1);
    drain("t5", 10);
    expq.delete();
    expq.push_back(mk(1'b1, 1'b1, 16'h0501)); expq.push_back(mk(1'b1, 1'b1, 16'h0511));
    expq.push_back(mk(1'b1, 1'b1, 16'h0502)); expq.push_back(mk(1'b1, 1'b1, 16'h0512));
    expq.push_back(mk(1'b1, 1'b1, 16'h0503)); expq.push_back(mk(1'b1, 1'b1, 16'h0513));
    cmp_out("t5");
    chkn("t5_pkt0", 32'(pkt_cnt0), 32'd6);
    chkn("t5_pkt1", 32'(pkt_cnt1), 32'd6);

    // Reset while locked on port 1 with a word held in the output register.
    outq.delete();
    q1.push_back(mk(1'b1, 1'b0, 16'h0601)); q1.push_back(mk(1'b0, 1'b0, 16'h0602));
    q1.push_back(mk(1'b0, 1'b1, 16'h0603));
    drive();
    tick();
    chkn("t6_lock_deq1", 32'(s_deq1), 32'd1);
    bus_if.fo_FULL_N = 1'b0;
    tick();
    chkn("t6_hold_enq", 32'(s_enq), 32'd0);
    bus_if.fo_FULL_N = 1'b1;
    #1;
    chkn("t6_pre_rst_enq", 32'(bus_if.fo_ENQ), 32'd1);
    RST = 1'b1;
    #1;
    chkn("t6_rst_enq", 32'(bus_if.fo_ENQ), 32'd0);
    chkn("t6_rst_deq1", 32'(bus_if.iport1_DEQ), 32'd0);
    chkn("t6_rst_busy", 32'(busy), 32'd0);
    chkn("t6_rst_pkt0", 32'(pkt_cnt0), 32'd0);
    chkn("t6_rst_pkt1", 32'(pkt_cnt1), 32'd0);
    chkn("t6_rst_drop", 32'(drop_cnt), 32'd0);
    q1.delete();
    drive();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    q0.push_back(mk(1'b1, 1'b1, 16'h0701));
    q1.push_back(mk(1'b1, 1'b1, 16'h0711));
    drive();
    tick();
    chkn("t6_grant_p0", 32'(s_deq0), 32'd1);
    chkn("t6_grant_not_p1", 32'(s_deq1), 32'd0);
    drain("t6", 10);
    expq.delete();
    expq.push_back(mk(1'b1, 1'b1, 16'h0701)); expq.push_back(mk(1'b1, 1'b1, 16'h0711));
    cmp_out("t6");
    chkn("t6_pkt0", 32'(pkt_cnt0), 32'd1);
    chkn("t6_pkt1", 32'(pkt_cnt1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
